risc_datapath: RTL and testbench
================================

// Module: risc_datapath
// PURPOSE
//  32-bit single-bus datapath of the RISC CPU, driven cycle-by-cycle by an external control unit or bench.
//  Contains R0-R15, PC, IR, MAR, MDR, HI, LO, Y, a 64-bit Z, an ALU, a 512x32 RAM, in/out ports and the CON flip-flop.
//  All register-to-register traffic moves over one shared 32-bit bus, one transfer per clock.
// PARAMETERS
//  DW 32 bus/register width; AW 9 RAM address width (512 words)
// PORTS
//  clock  in 1  single system clock, all state on posedge
//  clear  in 1  reset, asynchronous, active-low (0 = reset)
//  PCout,Zhighout,Zlowout,MDRout,HIout,LOout,Yout,InPortout,Cout  in 1 each  bus-source enables
//  MARin,PCin,MDRin,IRin,Yin,HIin,LOin,ZHighIn,ZLowIn,OutPortin,CONin  in 1 each  register loads
//  Gra,Grb,Grc,Rin,Rout,BAout  in 1 each  IR field select / GPR load / GPR drive / base-address drive
//  IncPC,Read,Write  in 1 each  ALU PC+1 / MDR takes RAM / RAM write
//  opcode  in 5  ALU operation;  Address in 9, Mdatain in 32  RAM preload port
//  InPortData  in 32  external input;  OutPortData  out 32  OutPort register
//  R0out..R15out  out 1 each  decoded GPR drive enables;  CON  out 1  branch-condition FF
// BEHAVIOUR
//  - Reset (clear=0, async): all registers incl. R0-R15, Z, CON, OutPort = 0. RAM is not cleared.
//    While clear=0 each posedge writes RAM[Address]<=Mdatain; out of reset Address/Mdatain are ignored.
//  - IR fields: [31:27] op, [26:23] Ra, [22:19] Rb, [18:15] Rc, [20:19] C2, [18:0] C.
//  - Select/encode: field = Gra?Ra : Grb?Rb : Grc?Rc : 0; decode one-hot.
//    Rjin = Rin & dec[j]; Rjout = (Rout|BAout) & dec[j], exported as R0out..R15out.
//  - Bus mux, priority: GPR, HI, LO, Zhigh, Zlow, PC, MDR, InPort, C, Y; 0 if none enabled.
//    R0 drives 0 when BAout=1. Cout drives sign-extended C (IR[18] replicated).
//  - ALU: A=Y, B=bus, result 64-bit. IncPC=1 overrides opcode: low = B+1.
//    Opcodes: 00011 add, 00100 sub, 00101 and, 00110 or, 00111 ror, 01000 rol, 01001 shr, 01010 shra, 01011 shl
//    (shift count B[4:0]), 10000 mul (signed, 64-bit), 01111 div (low=quotient, high=remainder, B=0 gives 0),
//    10001 neg B, 10010 not B; others give A+B. High half = 0 except mul/div.
//  - ZLowIn loads Z[31:0], ZHighIn loads Z[63:32] from the ALU result in the same edge.
//  - MDR loads Read ? RAM[MAR[8:0]] (async read) : bus. Write: RAM[MAR[8:0]] <= MDR on posedge.
//  - MAR, PC, IR, Y, HI, LO, OutPort load from the bus on posedge when enabled. InPort samples InPortData every posedge.
//  - CONin: CON <= cond(C2, bus): 00 bus==0, 01 bus!=0, 10 bus[31]==0, 11 bus[31]==1.
//  - Simultaneous loads all take the same bus value. Writes to R0 are allowed; R0 reads as 0 only via BAout.
// STRUCTURE
//  - Package risc_pkg: opcode localparams, DW/AW, IR field bit positions.
//  - One sub-module: risc_alu (combinational, 64-bit result).
//  - Select/encode, bus mux, RAM and CON logic stay inline.
// TESTING
//  - Reset: clear=0 mid-run -> every register, Z and OutPortData read 0 immediately, without a clock edge.
//  - Fetch: preload RAM[0]=0x00800065, PC=0.
//    T0 PCout,MARin,IncPC,ZLowIn -> T1 Zlowout,PCin,Read,MDRin -> T2 MDRout,IRin -> PC=1, IR=0x00800065.
//  - ld R1,0x65(R0): RAM[0x65]=0x84; T3 Grb,BAout,Yin (Y=0); T4 Cout,opcode=00011,ZLowIn (Z=0x65);
//    T5 Zlowout,MARin; T6 Read,MDRin; T7 Gra,Rin,MDRout -> R1=0x84, R1out asserted only with Rout.
//  - ALU: Y=7, bus=3: add->Z=10, sub->4, mul -> Zhigh=0/Zlow=21, div -> Zlow=2/Zhigh=1, shra of 0x80000000 by 4 -> 0xF8000000.
//  - CON: IR C2=01, bus=5, CONin -> CON=1; C2=00 with same bus -> CON=0.
//  - I/O: InPortData=0xABCD, InPortout+Rin -> Rj=0xABCD; OutPortin with bus=0x55 -> OutPortData=0x55.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared definitions for the single-bus RISC datapath: widths, IR field
// positions, ALU opcodes and the branch-condition helper used by CON.
package risc_pkg;

    localparam int DW      = 32;   // bus / register width
    localparam int AW      = 9;    // RAM address width (512 words)
    localparam int NUM_GPR = 16;

    // IR field positions
    localparam int OP_LSB = 27;    // [31:27] op
    localparam int RA_LSB = 23;    // [26:23] Ra
    localparam int RB_LSB = 19;    // [22:19] Rb
    localparam int RC_LSB = 15;    // [18:15] Rc
    localparam int C2_LSB = 19;    // [20:19] C2
    localparam int C_MSB  = 18;    // [18:0]  C

    // ALU opcodes
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    // Branch condition selected by the C2 field, evaluated on the bus value.
    function automatic logic branch_cond(input logic [1:0] c2, input logic [DW-1:0] value);
        case (c2)
            2'b00:   return value == '0;
            2'b01:   return value != '0;
            2'b10:   return !value[DW-1];
            default: return value[DW-1];
        endcase
    endfunction

endpackage

// File: rtl/risc_alu.sv
// Combinational ALU of the RISC datapath.
//   a_i      : operand A (Y register)
//   b_i      : operand B (bus); also the shift count via b_i[4:0]
//   opcode_i : operation select
//   inc_pc_i : overrides opcode, low half = B + 1
//   result_o : 64-bit result; high half is only non-zero for mul/div
module risc_alu
    import risc_pkg::*;
(
    input  logic [DW-1:0]   a_i,
    input  logic [DW-1:0]   b_i,
    input  logic [4:0]      opcode_i,
    input  logic            inc_pc_i,
    output logic [2*DW-1:0] result_o
);

    logic [4:0]      shamt;
    logic [2*DW-1:0] product;
    logic [DW-1:0]   quotient;
    logic [DW-1:0]   remainder;

    assign shamt   = b_i[4:0];
    // Operands sign-extended to full width so the product is a signed 64-bit multiply.
    assign product = $signed({{DW{a_i[DW-1]}}, a_i}) * $signed({{DW{b_i[DW-1]}}, b_i});
    // Signed divide; a zero divisor yields zero in both halves instead of X.
    assign quotient  = (b_i == '0) ? '0 : $signed(a_i) / $signed(b_i);
    assign remainder = (b_i == '0) ? '0 : $signed(a_i) % $signed(b_i);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        result_o = '0;
        if (inc_pc_i) begin
            result_o[DW-1:0] = b_i + DW'(1);
        end else begin
            case (opcode_i)
                OP_ADD:  result_o[DW-1:0] = a_i + b_i;
                OP_SUB:  result_o[DW-1:0] = a_i - b_i;
                OP_AND:  result_o[DW-1:0] = a_i & b_i;
                OP_OR:   result_o[DW-1:0] = a_i | b_i;
                // A shift by DW yields zero, so a rotate count of 0 stays correct.
                OP_ROR:  result_o[DW-1:0] = (a_i >> shamt) | (a_i << (DW - int'(shamt)));
                OP_ROL:  result_o[DW-1:0] = (a_i << shamt) | (a_i >> (DW - int'(shamt)));
                OP_SHR:  result_o[DW-1:0] = a_i >> shamt;
                OP_SHRA: result_o[DW-1:0] = $signed(a_i) >>> shamt;
                OP_SHL:  result_o[DW-1:0] = a_i << shamt;
                OP_MUL:  result_o         = product;
                OP_DIV:  result_o         = {remainder, quotient};
                OP_NEG:  result_o[DW-1:0] = -b_i;
                OP_NOT:  result_o[DW-1:0] = ~b_i;
                default: result_o[DW-1:0] = a_i + b_i;
            endcase
        end
    end

endmodule

// File: rtl/risc_datapath.sv
// Single-bus 32-bit RISC datapath, sequenced cycle by cycle from outside.
//   clock, clear      : system clock, asynchronous active-low reset
//   *out              : bus-source enables (priority GPR, HI, LO, Zhigh, Zlow, PC, MDR, InPort, C, Y)
//   *in / *In         : register loads from the bus (Z halves load from the ALU)
//   Gra/Grb/Grc       : choose the IR register field; Rin/Rout/BAout use it
//   IncPC, Read, Write: ALU B+1, MDR takes RAM, RAM takes MDR
//   opcode            : ALU operation
//   Address, Mdatain  : RAM preload port, active only while clear=0
//   InPortData        : external input; OutPortData: OutPort register
//   R0out..R15out     : decoded GPR drive enables; CON: branch-condition flag
module risc_datapath #(
    parameter int DW = risc_pkg::DW,
    parameter int AW = risc_pkg::AW
) (
    input  logic          clock,
    input  logic          clear,
    input  logic          PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Yout, InPortout, Cout,
    input  logic          MARin, PCin, MDRin, IRin, Yin, HIin, LOin, ZHighIn, ZLowIn, OutPortin, CONin,
    input  logic          Gra, Grb, Grc, Rin, Rout, BAout,
    input  logic          IncPC, Read, Write,
    input  logic [4:0]    opcode,
    input  logic [AW-1:0] Address,
    input  logic [DW-1:0] Mdatain,
    input  logic [DW-1:0] InPortData,
    output logic [DW-1:0] OutPortData,
    output logic          R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
    output logic          R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
    output logic          CON
);

    import risc_pkg::*;

    logic [DW-1:0]   r_q [NUM_GPR];
    logic [DW-1:0]   pc_q, ir_q, mar_q, mdr_q, hi_q, lo_q, y_q, inport_q, outport_q;
    logic [2*DW-1:0] z_q;
    logic            con_q;
    logic [DW-1:0]   ram [2**AW];

    logic [3:0]         reg_sel;
    logic [NUM_GPR-1:0] reg_dec, gpr_in_en, gpr_out_en;
    logic [DW-1:0]      c_sext;
    logic [DW-1:0]      bus;
    logic [2*DW-1:0]    alu_result;

    // Opcode field and upper MAR bits are not consumed by the datapath itself.
    logic unused_bits;
    assign unused_bits = ^{ir_q[DW-1:OP_LSB], mar_q[DW-1:AW]};

    // Select/encode: pick one IR register field, then decode one-hot.
    always_comb begin
        reg_sel = '0;
        if (Gra)      reg_sel = ir_q[RA_LSB +: 4];
        else if (Grb) reg_sel = ir_q[RB_LSB +: 4];
        else if (Grc) reg_sel = ir_q[RC_LSB +: 4];
    end

    assign reg_dec    = NUM_GPR'(1) << reg_sel;
    assign gpr_in_en  = {NUM_GPR{Rin}} & reg_dec;
    assign gpr_out_en = {NUM_GPR{Rout | BAout}} & reg_dec;
    assign {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
            R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out} = gpr_out_en;

    assign c_sext = {{(DW-C_MSB-1){ir_q[C_MSB]}}, ir_q[C_MSB:0]};

    // Bus mux; R0 reads as zero only when it is the base address (BAout).
    always_comb begin
        bus = '0;
        if (Rout || BAout)  bus = (BAout && reg_sel == 4'd0) ? '0 : r_q[reg_sel];
        else if (HIout)     bus = hi_q;
        else if (LOout)     bus = lo_q;
        else if (Zhighout)  bus = z_q[2*DW-1:DW];
        else if (Zlowout)   bus = z_q[DW-1:0];
        else if (PCout)     bus = pc_q;
        else if (MDRout)    bus = mdr_q;
        else if (InPortout) bus = inport_q;
        else if (Cout)      bus = c_sext;
        else if (Yout)      bus = y_q;
    end

    risc_alu u_alu (
        .a_i      (y_q),
        .b_i      (bus),
        .opcode_i (opcode),
        .inc_pc_i (IncPC),
        .result_o (alu_result)
    );

    // NOTE: sequential state uses non-blocking assignments so all loads see the pre-edge bus.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int j = 0; j < NUM_GPR; j++) r_q[j] <= '0;
            pc_q      <= '0;
            ir_q      <= '0;
            mar_q     <= '0;
            mdr_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            y_q       <= '0;
            z_q       <= '0;
            inport_q  <= '0;
            outport_q <= '0;
            con_q     <= 1'b0;
        end else begin
            for (int j = 0; j < NUM_GPR; j++) begin
                if (gpr_in_en[j]) r_q[j] <= bus;
            end
            if (PCin)      pc_q      <= bus;
            if (IRin)      ir_q      <= bus;
            if (MARin)     mar_q     <= bus;
            if (MDRin)     mdr_q     <= Read ? ram[mar_q[AW-1:0]] : bus;
            if (HIin)      hi_q      <= bus;
            if (LOin)      lo_q      <= bus;
            if (Yin)       y_q       <= bus;
            if (ZLowIn)    z_q[DW-1:0]    <= alu_result[DW-1:0];
            if (ZHighIn)   z_q[2*DW-1:DW] <= alu_result[2*DW-1:DW];
            if (OutPortin) outport_q <= bus;
            if (CONin)     con_q     <= branch_cond(ir_q[C2_LSB +: 2], bus);
            inport_q <= InPortData;
        end
    end

    // NOTE: the RAM has no reset; clear only turns its write port over to the preload inputs.
    always_ff @(posedge clock) begin
        if (!clear)     ram[Address] <= Mdatain;
        else if (Write) ram[mar_q[AW-1:0]] <= mdr_q;
    end

    assign OutPortData = outport_q;
    assign CON         = con_q;

endmodule

// File: tb/tb_risc_datapath.sv
// Directed and randomized checks of risc_datapath against a behavioural model.
module tb_risc_datapath;

    import risc_pkg::*;

    logic        clock = 1'b0;
    logic        clear;
    logic        PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Yout, InPortout, Cout;
    logic        MARin, PCin, MDRin, IRin, Yin, HIin, LOin, ZHighIn, ZLowIn, OutPortin, CONin;
    logic        Gra, Grb, Grc, Rin, Rout, BAout, IncPC, Read, Write;
    logic [4:0]  opcode;
    logic [8:0]  Address;
    logic [31:0] Mdatain, InPortData;
    logic [31:0] OutPortData;
    logic        R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out;
    logic        R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out;
    logic        CON;
    logic [15:0] rout_vec;

    int checks = 0;
    int errors = 0;
    logic [31:0] model_r [16];
    logic [4:0]  op_list [13];

    assign rout_vec = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                       R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};

    always #5 clock = ~clock;

    risc_datapath dut (
        .clock(clock), .clear(clear),
        .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout), .HIout(HIout),
        .LOout(LOout), .Yout(Yout), .InPortout(InPortout), .Cout(Cout),
        .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .HIin(HIin),
        .LOin(LOin), .ZHighIn(ZHighIn), .ZLowIn(ZLowIn), .OutPortin(OutPortin), .CONin(CONin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .IncPC(IncPC), .Read(Read), .Write(Write), .opcode(opcode),
        .Address(Address), .Mdatain(Mdatain), .InPortData(InPortData), .OutPortData(OutPortData),
        .R0out(R0out), .R1out(R1out), .R2out(R2out), .R3out(R3out), .R4out(R4out), .R5out(R5out),
        .R6out(R6out), .R7out(R7out), .R8out(R8out), .R9out(R9out), .R10out(R10out),
        .R11out(R11out), .R12out(R12out), .R13out(R13out), .R14out(R14out), .R15out(R15out),
        .CON(CON)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_ctrl();
        {PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Yout, InPortout, Cout} = '0;
        {MARin, PCin, MDRin, IRin, Yin, HIin, LOin, ZHighIn, ZLowIn, OutPortin, CONin} = '0;
        {Gra, Grb, Grc, Rin, Rout, BAout, IncPC, Read, Write} = '0;
        opcode = '0;
    endtask

    // One clock: inputs set before are sampled, controls are dropped 1 ns after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
        clr_ctrl();
    endtask

    // Put a value on the InPort register; leaves InPortout asserted for the next step.
    task automatic put(input logic [31:0] v);
        InPortData = v;
        tick();
        InPortout = 1'b1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_r0"},  dut.r_q[0], 0);
        check({tag, "_r1"},  dut.r_q[1], 0);
        check({tag, "_r15"}, dut.r_q[15], 0);
        check({tag, "_pc"},  dut.pc_q, 0);
        check({tag, "_ir"},  dut.ir_q, 0);
        check({tag, "_mar"}, dut.mar_q, 0);
        check({tag, "_mdr"}, dut.mdr_q, 0);
        check({tag, "_hi"},  dut.hi_q, 0);
        check({tag, "_lo"},  dut.lo_q, 0);
        check({tag, "_y"},   dut.y_q, 0);
        check({tag, "_z"},   dut.z_q, 0);
        check({tag, "_out"}, OutPortData, 0);
        check({tag, "_con"}, CON, 0);
    endtask

    // Reference ALU computed directly from the operation definitions.
    function automatic logic [63:0] alu_model(input logic [4:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic inc);
        logic [31:0] r;
        longint      p;
        int          n, sa, sb;
        n  = int'(b[4:0]);
        sa = a;
        sb = b;
        r  = a;
        if (inc) return {32'd0, b + 32'd1};
        case (op)
            5'b00011: return {32'd0, a + b};
            5'b00100: return {32'd0, a - b};
            5'b00101: return {32'd0, a & b};
            5'b00110: return {32'd0, a | b};
            5'b00111: begin repeat (n) r = {r[0], r[31:1]}; return {32'd0, r}; end
            5'b01000: begin repeat (n) r = {r[30:0], r[31]}; return {32'd0, r}; end
            5'b01001: return {32'd0, a >> n};
            5'b01010: begin repeat (n) r = {r[31], r[31:1]}; return {32'd0, r}; end
            5'b01011: return {32'd0, a << n};
            5'b10000: begin p = longint'(sa) * longint'(sb); return p; end
            5'b01111: begin
                if (b == 0) return 64'd0;
                return {32'(sa % sb), 32'(sa / sb)};
            end
            5'b10001: return {32'd0, 32'd0 - b};
            5'b10010: return {32'd0, ~b};
            default:  return {32'd0, a + b};
        endcase
    endfunction

    // Y <= a, then bus = b through the ALU into both Z halves.
    task automatic alu_case(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] op, input logic inc, input logic [63:0] exp);
        put(a);
        Yin        = 1'b1;
        InPortData = b;
        tick();
        InPortout = 1'b1;
        opcode    = op;
        IncPC     = inc;
        ZLowIn    = 1'b1;
        ZHighIn   = 1'b1;
        tick();
        check(tag, dut.z_q, exp);
    endtask

    task automatic con_case(input string tag, input logic [31:0] ir, input logic [31:0] v,
                            input logic exp);
        put(ir);
        IRin = 1'b1;
        tick();
        put(v);
        CONin = 1'b1;
        tick();
        check(tag, CON, exp);
    endtask

    initial begin
        logic [31:0] a, b, w;
        logic [4:0]  op;
        logic        inc;
        int          j;

        op_list = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000, 5'b01001,
                    5'b01010, 5'b01011, 5'b10000, 5'b01111, 5'b10001, 5'b11111};
        clr_ctrl();
        clear = 1'b0; Address = '0; Mdatain = '0; InPortData = '0;
        #1;
        check_zero("por");

        // Preload RAM while in reset.
        Address = 9'h000; Mdatain = 32'h0080_0065; tick();
        Address = 9'h065; Mdatain = 32'h0000_0084; tick();
        Address = 9'h1FF; Mdatain = 32'hCAFE_F00D; tick();
        clear = 1'b1;
        Address = 9'h000; Mdatain = 32'hDEAD_BEEF; tick();   // must be ignored

        // Make R0 non-zero so BAout has something to mask.
        put(32'h1234); Gra = 1'b1; Rin = 1'b1; tick();
        check("r0_write", dut.r_q[0], 32'h1234);

        // Instruction fetch.
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ZLowIn = 1'b1; tick();
        check("t0_z", dut.z_q, 64'd1);
        Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; tick();
        MDRout = 1'b1; IRin = 1'b1; tick();
        check("fetch_pc", dut.pc_q, 32'd1);
        check("fetch_ir", dut.ir_q, 32'h0080_0065);

        // ld R1,0x65(R0)
        Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
        #1 check("t3_r0out", rout_vec, 16'h0001);
        tick();
        check("t3_y", dut.y_q, 32'd0);
        Cout = 1'b1; opcode = OP_ADD; ZLowIn = 1'b1; tick();
        check("t4_z", dut.z_q, 64'h65);
        Zlowout = 1'b1; MARin = 1'b1; tick();
        Read = 1'b1; MDRin = 1'b1; tick();
        check("t6_mdr", dut.mdr_q, 32'h84);
        Gra = 1'b1; Rin = 1'b1; MDRout = 1'b1; tick();
        check("t7_r1", dut.r_q[1], 32'h84);
        Gra = 1'b1;
        #1 check("r1out_no_rout", rout_vec, 16'h0000);
        Rout = 1'b1;
        #1 check("r1out_rout", rout_vec, 16'h0002);
        tick();

        // RAM: only MAR[8:0] addresses memory; write then read back.
        put(32'hFFFF_FFFF); MARin = 1'b1; tick();
        Read = 1'b1; MDRin = 1'b1; tick();
        check("ram_top_word", dut.mdr_q, 32'hCAFE_F00D);
        w = $urandom;
        put(w); MDRin = 1'b1; tick();
        Write = 1'b1; tick();
        put(32'd0); MDRin = 1'b1; tick();
        Read = 1'b1; MDRin = 1'b1; tick();
        check("ram_write_read", dut.mdr_q, w);

        // Directed ALU cases.
        alu_case("alu_add", 7, 3, OP_ADD, 1'b0, 64'd10);
        alu_case("alu_sub", 7, 3, OP_SUB, 1'b0, 64'd4);
        alu_case("alu_div", 7, 3, OP_DIV, 1'b0, 64'h0000_0001_0000_0002);
        alu_case("alu_div0", 7, 0, OP_DIV, 1'b0, 64'd0);
        alu_case("alu_shra", 32'h8000_0000, 4, OP_SHRA, 1'b0, 64'h0000_0000_F800_0000);
        alu_case("alu_incpc_wrap", 5, 32'hFFFF_FFFF, OP_MUL, 1'b1, 64'd0);
        alu_case("alu_mul_neg", 32'hFFFF_FFF9, 3, OP_MUL, 1'b0, 64'hFFFF_FFFF_FFFF_FFEB);
        alu_case("alu_mul", 7, 3, OP_MUL, 1'b0, 64'd21);
        Zhighout = 1'b1; HIin = 1'b1; tick();
        Zlowout = 1'b1; LOin = 1'b1; tick();
        check("hi_mul", dut.hi_q, 32'd0);
        check("lo_mul", dut.lo_q, 32'd21);

        // Randomized ALU against the model.
        for (int k = 0; k < 40; k++) begin
            op  = op_list[$urandom_range(0, 12)];
            a   = $urandom;
            b   = $urandom;
            inc = ($urandom_range(0, 7) == 0);
            if (op == 5'b01111) begin
                a[31] = 1'b0;
                b[31] = 1'b0;
                if ($urandom_range(0, 3) == 0) b = 0;
            end
            alu_case($sformatf("alu_rand_%0d_op%0b", k, op), a, b, op, inc, alu_model(op, a, b, inc));
        end

        // Cout sign-extends C.
        put(32'h0004_0005); IRin = 1'b1; tick();
        Cout = 1'b1; Yin = 1'b1; tick();
        check("c_sext", dut.y_q, 32'hFFFC_0005);

        // CON flip-flop.
        con_case("con_ne",      32'h0008_0000, 32'd5, 1'b1);
        con_case("con_eq",      32'h0000_0000, 32'd5, 1'b0);
        con_case("con_eq_zero", 32'h0000_0000, 32'd0, 1'b1);
        con_case("con_ge",      32'h0010_0000, 32'h8000_0000, 1'b0);
        con_case("con_lt",      32'h0018_0000, 32'h8000_0000, 1'b1);

        // I/O ports.
        put(32'd3 << 23); IRin = 1'b1; tick();
        InPortData = 32'hABCD; tick();
        InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; tick();
        check("inport_r3", dut.r_q[3], 32'hABCD);
        put(32'h55); OutPortin = 1'b1; tick();
        check("outport", OutPortData, 32'h55);

        // Register file: random writes through Ra, read back through Rb/Rc onto OutPort.
        for (int k = 0; k < 36; k++) begin
            j = (k < 16) ? k : int'($urandom_range(0, 15));
            w = $urandom;
            model_r[j] = w;
            put(32'(j) << 23); IRin = 1'b1; tick();
            put(w); Gra = 1'b1; Rin = 1'b1; tick();
        end
        for (int k = 0; k < 16; k++) begin
            put((k % 2 == 1) ? (32'(k) << 15) : (32'(k) << 19)); IRin = 1'b1; tick();
            Grc = (k % 2 == 1); Grb = (k % 2 == 0); Rout = 1'b1; OutPortin = 1'b1;
            #1 check($sformatf("rout_dec_%0d", k), rout_vec, 16'd1 << k);
            tick();
            check($sformatf("gpr_read_%0d", k), OutPortData, model_r[k]);
        end

        // Asynchronous reset mid-run, no clock edge in between.
        @(posedge clock);
        #2 clear = 1'b0;
        #1 check_zero("async");
        tick();
        clear = 1'b1;
        tick();
        // RAM contents survive reset.
        put(32'h65); MARin = 1'b1; tick();
        Read = 1'b1; MDRin = 1'b1; tick();
        check("ram_after_reset", dut.mdr_q, 32'h84);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
